// File: rtl/cdc_tx_arb_pkg.sv
// rtl/cdc_tx_arb_pkg.sv - shared types and constants for the CDC transmit arbiter
package cdc_tx_arb_pkg;

   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

   typedef enum logic [1:0] {
      REQ_UART  = 2'd0,
      REQ_SCAN  = 2'd1,
      REQ_GPIO  = 2'd2,
      REQ_SPARE = 2'd3
   } req_id_e;

   // Requester ID width; a single requester bit is kept even for tiny NUM_REQ.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cdc_tx_arbiter_rr_pick.sv
// rtl/cdc_tx_arbiter_rr_pick.sv - rotating-priority one-hot picker
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Search offsets ptr, ptr+1, ... with a modulo so non-power-of-two N wraps cleanly.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i == ((int'(ptr) + k) % N))) begin
               any      = 1'b1;
               grant[i] = 1'b1;
               idx      = IW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/cdc_tx_arbiter.sv
// rtl/cdc_tx_arbiter.sv - round-robin scheduler feeding one handshake CDC channel
// Optional stall watchdog enabled by CDC_TX_ARB_WATCHDOG_EN.
module cdc_tx_arbiter
   import cdc_tx_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_W         = 8,
   parameter int ID_W           = id_width(NUM_REQ),
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                      clk,
   input  logic                      async_reset_n,
   input  logic                      arb_en,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [ID_W+DATA_W-1:0]    out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      busy,
   output logic                      err_stall,
   input  logic                      err_clear
);

   logic [ID_W-1:0]    rr_ptr;
   logic [NUM_REQ-1:0] win_oh;
   logic [ID_W-1:0]    win_idx;
   logic               win_any;
   logic [DATA_W-1:0]  win_data;
   logic               reg_free;
   logic               grant;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (ID_W)
   ) u_rr_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (win_oh),
      .idx   (win_idx),
      .any   (win_any)
   );

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == ID_W'(i)) begin
            win_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign reg_free  = !out_valid || out_ready;
   assign grant     = arb_en && reg_free && win_any && async_reset_n;
   assign req_ready = grant ? win_oh : '0;
   assign busy      = out_valid || (|req_valid);

   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         rr_ptr    <= '0;
      end else if (grant) begin
         out_valid <= 1'b1;
         out_data  <= {win_idx, win_data};
         rr_ptr    <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef CDC_TX_ARB_WATCHDOG_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] stall_cnt;
   logic             stalled;
   logic             stall_hit;

   assign stalled   = out_valid && !out_ready;
   // Fires on the edge where the count lands on the threshold and keeps firing while saturated.
   assign stall_hit = stalled && (stall_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         stall_cnt <= '0;
         err_stall <= 1'b0;
      end else begin
         if (!stalled) begin
            stall_cnt <= '0;
         end else if (stall_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (stall_hit) begin
            err_stall <= 1'b1;
         end else if (err_clear) begin
            err_stall <= 1'b0;
         end
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   logic unused_err_clear;

   assign unused_err_clear = err_clear;
   assign err_stall        = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// tb/tb_cdc_tx_arbiter.sv - self-checking bench for cdc_tx_arbiter
module tb_cdc_tx_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int IW = 2;
`ifdef CDC_TX_ARB_WATCHDOG_EN
   localparam int TO = 16;
`else
   localparam int TO = 1024;
`endif

   logic              clk = 1'b0;
   logic              async_reset_n;
   logic              arb_en;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*DW-1:0]   req_data;
   logic [IW+DW-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              err_stall;
   logic              err_clear;

   int nvec = 0;
   int nerr = 0;

   cdc_tx_arbiter #(
      .NUM_REQ        (N),
      .DATA_W         (DW),
      .ID_W           (IW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .async_reset_n (async_reset_n),
      .arb_en        (arb_en),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_data      (req_data),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .busy          (busy),
      .err_stall     (err_stall),
      .err_clear     (err_clear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      async_reset_n = 1'b0;
      arb_en    = 1'b0;
      req_valid = '0;
      out_ready = 1'b0;
      err_clear = 1'b0;
      repeat (2) @(negedge clk);
      async_reset_n = 1'b1;
   endtask

   typedef struct {
      logic         en;
      logic [N-1:0] valid;
      logic         rdy;
      logic [N-1:0] exp_ready;
      logic         exp_ov;
      logic [9:0]   exp_od;
   } vec_t;

   vec_t tbl[20];

   // Reference model: round-robin pointer as plain integer, held word, stall run length.
   int          m_ptr;
   logic        m_valid;
   logic [9:0]  m_data;
   int          m_run;
   logic        m_err;

   function automatic int pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   initial begin
      async_reset_n = 1'b0;
      arb_en    = 1'b0;
      req_valid = '0;
      out_ready = 1'b0;
      err_clear = 1'b0;
      req_data  = '0;

      //          en  valid    rdy exp_ready exp_ov exp_od
      tbl[0]  = '{1, 4'b1111, 1, 4'b0001, 0, 10'h000};
      tbl[1]  = '{1, 4'b1111, 1, 4'b0010, 1, 10'h0A0};
      tbl[2]  = '{1, 4'b1111, 1, 4'b0100, 1, 10'h1A1};
      tbl[3]  = '{1, 4'b1111, 1, 4'b1000, 1, 10'h2A2};
      tbl[4]  = '{1, 4'b1111, 1, 4'b0001, 1, 10'h3A3};
      tbl[5]  = '{1, 4'b0000, 1, 4'b0000, 1, 10'h0A0};
      tbl[6]  = '{1, 4'b0000, 1, 4'b0000, 0, 10'h0A0};
      tbl[7]  = '{1, 4'b0010, 1, 4'b0010, 0, 10'h0A0};
      tbl[8]  = '{1, 4'b0100, 1, 4'b0100, 1, 10'h1A1};
      tbl[9]  = '{1, 4'b0010, 1, 4'b0010, 1, 10'h2A2};
      tbl[10] = '{1, 4'b1001, 1, 4'b1000, 1, 10'h1A1};
      tbl[11] = '{1, 4'b1001, 1, 4'b0001, 1, 10'h3A3};
      tbl[12] = '{1, 4'b0000, 0, 4'b0000, 1, 10'h0A0};
      tbl[13] = '{1, 4'b0000, 0, 4'b0000, 1, 10'h0A0};
      tbl[14] = '{0, 4'b1111, 0, 4'b0000, 1, 10'h0A0};
      tbl[15] = '{0, 4'b1111, 1, 4'b0000, 1, 10'h0A0};
      tbl[16] = '{0, 4'b1111, 1, 4'b0000, 0, 10'h0A0};
      tbl[17] = '{1, 4'b1111, 1, 4'b0010, 0, 10'h0A0};
      tbl[18] = '{1, 4'b0000, 1, 4'b0000, 1, 10'h1A1};
      tbl[19] = '{1, 4'b0000, 1, 4'b0000, 0, 10'h1A1};

      // Table-driven round-robin, sparse/wrap and arb_en sequences
      do_reset();
      #1;
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_out_data", 32'(out_data), 0);
      chk("reset_err_stall", 32'(err_stall), 0);
      req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         arb_en    = tbl[i].en;
         req_valid = tbl[i].valid;
         out_ready = tbl[i].rdy;
         #1;
         chk($sformatf("tbl%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
         chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
         chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].exp_od));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_ov | (|tbl[i].valid)));
      end

      // Async reset in the middle of a held word
      @(negedge clk);
      arb_en = 1'b1; req_valid = 4'b1111; out_ready = 1'b0;
      @(negedge clk);
      #2;
      async_reset_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_req_ready", 32'(req_ready), 0);
      chk("midrst_out_data", 32'(out_data), 0);
      @(negedge clk);
      async_reset_n = 1'b1;
      #1;
      chk("postrst_first_grant", 32'(req_ready), 32'(4'b0001));

      // Backpressure on a single requester, others waiting behind it
      do_reset();
      req_data = {8'h33, 8'h5C, 8'h11, 8'h00};
      @(negedge clk);
      arb_en = 1'b1; req_valid = 4'b0100; out_ready = 1'b0;
      #1;
      chk("bp_grant_req2", 32'(req_ready), 32'(4'b0100));
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         req_valid = 4'b1111;
         #1;
         chk($sformatf("bp_hold_data%0d", c), 32'(out_data), 32'h25C);
         chk($sformatf("bp_hold_ready%0d", c), 32'(req_ready), 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready), 32'(4'b1000));
      @(negedge clk);
      #1;
      chk("bp_next_data", 32'(out_data), 32'h333);
      chk("bp_next_valid", 32'(out_valid), 1);

`ifdef CDC_TX_ARB_WATCHDOG_EN
      // Stall watchdog: set after TO stalled cycles, set beats clear, clear after release
      do_reset();
      @(negedge clk);
      arb_en = 1'b1; req_valid = 4'b0001; out_ready = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         req_valid = '0;
      end
      #1;
      chk("wd_before_timeout", 32'(err_stall), 0);
      @(negedge clk);
      #1;
      chk("wd_at_timeout", 32'(err_stall), 1);
      err_clear = 1'b1;
      @(negedge clk);
      #1;
      chk("wd_set_beats_clear", 32'(err_stall), 1);
      chk("wd_word_kept", 32'(out_valid), 1);
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("wd_cleared", 32'(err_stall), 0);
      err_clear = 1'b0;
`endif

      // Randomized run against the reference model
      do_reset();
      m_ptr = 0; m_valid = 1'b0; m_data = '0; m_run = 0; m_err = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int w;
         logic [N-1:0] exp_ready;
         logic stalled;
         @(negedge clk);
         arb_en    = ($urandom_range(0, 7) != 0);
         req_valid = N'($urandom);
         req_data  = $urandom;
         out_ready = ((cyc % 300) < 40) ? 1'b0 : 1'($urandom_range(0, 1));
         err_clear = ($urandom_range(0, 15) == 0);
         #1;
         w = -1;
         if (arb_en && (!m_valid || out_ready)) w = pick(req_valid, m_ptr);
         exp_ready = (w >= 0) ? N'(1 << w) : '0;
         chk("rnd_req_ready", 32'(req_ready), 32'(exp_ready));
         chk("rnd_out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) chk("rnd_out_data", 32'(out_data), 32'(m_data));
         chk("rnd_busy", 32'(busy), 32'(m_valid | (|req_valid)));
         chk("rnd_err_stall", 32'(err_stall), 32'(m_err));
`ifdef CDC_TX_ARB_WATCHDOG_EN
         stalled = m_valid && !out_ready;
         m_run = stalled ? m_run + 1 : 0;
         if (stalled && m_run >= TO) m_err = 1'b1;
         else if (err_clear) m_err = 1'b0;
`else
         stalled = 1'b0;
         m_err = stalled;
`endif
         if (w >= 0) begin
            m_valid = 1'b1;
            m_data  = {2'(w), req_data[w*DW +: DW]};
            m_ptr   = (w + 1) % N;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
